// File: rtl/cartridge_loader_pkg.sv
//------------------------------------------------------------------------------
// cartridge_loader_pkg -- colour codes, word geometry and loader state encoding | rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cartridge_loader_pkg;

   localparam int NIBS_PER_WORD_DEF = 6;
   localparam int DATA_W_DEF        = 2 * NIBS_PER_WORD_DEF;

   localparam logic [1:0] COLOR_RED    = 2'b00;
   localparam logic [1:0] COLOR_GREEN  = 2'b01;
   localparam logic [1:0] COLOR_BLUE   = 2'b10;
   localparam logic [1:0] COLOR_YELLOW = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_FLUSH   = 2'd2,
      ST_DONE    = 2'd3
   } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/cartridge_loader_nib_packer.sv
//------------------------------------------------------------------------------
// nib_packer -- MSB-first colour-nib shift register with zero-padding on demand | rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module nib_packer
   import cartridge_loader_pkg::*;
#(
   parameter int NIBS_PER_WORD = NIBS_PER_WORD_DEF,
   parameter int DATA_W        = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              shift_en,
   input  logic [1:0]        color,
   input  logic              pad,
   output logic [DATA_W-1:0] word,
   output logic              word_ready,
   output logic              partial
);

   localparam int               CNT_W    = $clog2(NIBS_PER_WORD + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NIBS_PER_WORD);

   logic [DATA_W-1:0] shift_reg;
   logic [DATA_W-1:0] packed_word;
   logic [CNT_W-1:0]  nib_cnt;
   logic [CNT_W-1:0]  cnt_after;
   logic [CNT_W-1:0]  pad_nibs;
   logic [CNT_W:0]    pad_bits;

   // The nib arriving this cycle is packed before any padding is decided.
   always_comb begin
      packed_word = shift_reg;
      cnt_after   = nib_cnt;
      if (shift_en) begin
         packed_word = {shift_reg[DATA_W-3:0], color};
         cnt_after   = nib_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      pad_nibs   = FULL_CNT - cnt_after;
      pad_bits   = {pad_nibs, 1'b0};
      word       = packed_word << pad_bits;
      word_ready = (cnt_after == FULL_CNT) || (pad && (cnt_after != '0));
      partial    = !word_ready && (cnt_after != '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shift_reg <= '0;
         nib_cnt   <= '0;
      end else if (clear || word_ready) begin
         shift_reg <= '0;
         nib_cnt   <= '0;
      end else if (shift_en) begin
         shift_reg <= packed_word;
         nib_cnt   <= cnt_after;
      end
   end

endmodule

`default_nettype wire

// File: rtl/cartridge_loader.sv
//------------------------------------------------------------------------------
// cartridge_loader -- packs colour nibs into words and drives the program RAM write port | rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cartridge_loader
   import cartridge_loader_pkg::*;
#(
   parameter int NIBS_PER_WORD = NIBS_PER_WORD_DEF,
   parameter int DATA_W        = DATA_W_DEF,
   parameter int ADDR_W        = 8,
   parameter int DEPTH         = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              color_valid,
   input  logic [1:0]        color,
   input  logic              row_end,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              load_active,
   output logic              load_done,
   output logic [ADDR_W:0]   word_count,
   output logic              overflow
);

   localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   loader_state_t state;
   loader_state_t state_next;
   logic          restart;

   logic [DATA_W-1:0] word;
   logic              word_ready;
   logic              partial;
   logic              full;

   logic in_collect;
   logic in_flush;
   logic clear_req;
   logic shift_en;
   logic pad_req;
   logic accept;
   logic drop;

   nib_packer #(
      .NIBS_PER_WORD (NIBS_PER_WORD),
      .DATA_W        (DATA_W)
   ) u_nib_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear_req),
      .shift_en   (shift_en),
      .color      (color),
      .pad        (pad_req),
      .word       (word),
      .word_ready (word_ready),
      .partial    (partial)
   );

   // A write still on the bus has not been counted yet, so it already occupies a slot.
   assign full = (word_count + (ADDR_W + 1)'(wr_en)) >= DEPTH_C;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         restart <= 1'b0;
      end else begin
         state   <= state_next;
         restart <= (state == ST_DONE) && start;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (start || restart) state_next = ST_COLLECT;
         end
         ST_COLLECT: begin
            if (word_ready && full) state_next = ST_DONE;
            else if (stop)          state_next = partial ? ST_FLUSH : ST_DONE;
         end
         ST_FLUSH: begin
            state_next = ST_DONE;
         end
         ST_DONE: begin
            if (start) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      in_collect  = (state == ST_COLLECT);
      in_flush    = (state == ST_FLUSH);
      load_active = in_collect || in_flush;
      load_done   = (state == ST_DONE);
      clear_req   = (state == ST_IDLE);
      shift_en    = in_collect && color_valid;
      pad_req     = (in_collect && row_end) || in_flush;
      accept      = load_active && word_ready && !full;
      drop        = load_active && word_ready && full;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_en      <= 1'b0;
         wr_data    <= '0;
         wr_addr    <= '0;
         word_count <= '0;
         overflow   <= 1'b0;
      end else begin
         wr_en <= accept;
         if (accept) wr_data <= word;
         if (clear_req) begin
            wr_addr    <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
         end else begin
            if (wr_en && (wr_addr != ADDR_MAX))   wr_addr    <= wr_addr + ADDR_W'(1);
            if (wr_en && (word_count != DEPTH_C)) word_count <= word_count + (ADDR_W + 1)'(1);
            if (drop)                             overflow   <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire
